// File: rtl/i2s_seq_transmitter.sv
// Double-buffered I2S DAC serializer: streams SEQ_LEN stereo samples per block,
// MSB first, aligned to codec-driven DACLRCK with the I2S one-BCLK delay.
module i2s_seq_transmitter #(
    parameter int DATA_W  = 16,
    parameter int SEQ_LEN = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_lrc,
    input  logic                            i_load,
    input  logic [SEQ_LEN-1:0][DATA_W-1:0]  i_seq_l,
    input  logic [SEQ_LEN-1:0][DATA_W-1:0]  i_seq_r,
    output logic                            o_dacdat,
    output logic                            o_ready,
    output logic                            o_busy,
    output logic                            o_underrun,
    output logic                            o_overflow
);

    localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEQ_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t                           state_q, state_d;
    logic                             lrc_q;
    logic [SEQ_LEN-1:0][DATA_W-1:0]   shadow_l_q, shadow_r_q;
    logic [SEQ_LEN-1:0][DATA_W-1:0]   active_l_q, active_r_q;
    logic                             shadow_vld_q;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic                             exhausted_q, exhausted_d;
    logic                             started_q, started_d;
    logic [DATA_W-1:0]                shift_q;
    logic [CNT_W-1:0]                 cnt_q;
    logic                             dacdat_q;
    logic                             underrun_q, underrun_d;
    logic                             overflow_q;

    logic                             fall, rise, block_start;
    logic                             take_shadow, bypass, send, load_shadow;
    logic [DATA_W-1:0]                word;

    assign fall        = lrc_q & ~i_lrc;
    assign rise        = ~lrc_q & i_lrc;
    // A left slot starts a new block when idle or when the active bank is used up.
    assign block_start = fall & ((state_q == S_IDLE) | exhausted_q);
    assign load_shadow = i_load & ~shadow_vld_q & ~bypass;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        exhausted_d = exhausted_q;
        started_d   = started_q;
        underrun_d  = 1'b0;
        take_shadow = 1'b0;
        bypass      = 1'b0;
        send        = 1'b0;
        word        = '0;
        if (block_start) begin
            send = 1'b1;
            if (shadow_vld_q) begin
                take_shadow = 1'b1;
                word        = shadow_l_q[0];
            end else if (i_load) begin
                bypass = 1'b1;
                word   = i_seq_l[0];
            end else begin
                underrun_d = started_q;
                state_d    = S_IDLE;
            end
            if (take_shadow || bypass) begin
                state_d     = S_STREAM;
                idx_d       = '0;
                exhausted_d = 1'b0;
                started_d   = 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    send = fall | rise;
                end
                S_STREAM: begin
                    if (fall) begin
                        send = 1'b1;
                        word = active_l_q[idx_q];
                    end else if (rise) begin
                        send = 1'b1;
                        if (!exhausted_q) begin
                            word = active_r_q[idx_q];
                            if (idx_q == IDX_LAST) begin
                                idx_d       = '0;
                                exhausted_d = 1'b1;
                            end else begin
                                idx_d = idx_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            lrc_q        <= 1'b0;
            idx_q        <= '0;
            exhausted_q  <= 1'b0;
            started_q    <= 1'b0;
            underrun_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lrc_q        <= i_lrc;
            idx_q        <= idx_d;
            exhausted_q  <= exhausted_d;
            started_q    <= started_d;
            underrun_q   <= underrun_d;
            overflow_q   <= i_load & shadow_vld_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shadow_vld_q <= 1'b0;
            shadow_l_q   <= '0;
            shadow_r_q   <= '0;
            active_l_q   <= '0;
            active_r_q   <= '0;
        end else begin
            if (load_shadow) begin
                shadow_vld_q <= 1'b1;
                shadow_l_q   <= i_seq_l;
                shadow_r_q   <= i_seq_r;
            end else if (take_shadow) begin
                shadow_vld_q <= 1'b0;
            end
            if (take_shadow) begin
                active_l_q <= shadow_l_q;
                active_r_q <= shadow_r_q;
            end else if (bypass) begin
                active_l_q <= i_seq_l;
                active_r_q <= i_seq_r;
            end
        end
    end

    // MSB leaves on the edge-detect posedge; a new edge always reloads the shifter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shift_q  <= '0;
            cnt_q    <= '0;
            dacdat_q <= 1'b0;
        end else if (send) begin
            dacdat_q <= word[DATA_W-1];
            shift_q  <= {word[DATA_W-2:0], 1'b0};
            cnt_q    <= CNT_LAST;
        end else if (cnt_q != '0) begin
            dacdat_q <= shift_q[DATA_W-1];
            shift_q  <= {shift_q[DATA_W-2:0], 1'b0};
            cnt_q    <= cnt_q - 1'b1;
        end else begin
            dacdat_q <= 1'b0;
        end
    end

    assign o_dacdat   = dacdat_q;
    assign o_ready    = ~shadow_vld_q;
    assign o_busy     = (state_q == S_STREAM);
    assign o_underrun = underrun_q;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_i2s_seq_transmitter.sv
// Directed bench for i2s_seq_transmitter: slot-by-slot word capture against
// hand-computed sample values, plus reset, overflow, underrun and bypass cases.
module tb_i2s_seq_transmitter;

    localparam int DW   = 16;
    localparam int SL   = 16;
    localparam int SLOT = 32;

    logic                   clk = 1'b0;
    logic                   rst, lrc, load;
    logic [SL-1:0][DW-1:0]  seq_l, seq_r;
    logic                   dacdat, ready, busy, underrun, overflow;

    int n_tests  = 0;
    int n_fail   = 0;
    int n_under  = 0;
    int n_over   = 0;
    int tail_err = 0;

    typedef struct {
        logic        lrc;
        logic        load;
        logic [15:0] lbase;
        logic [15:0] exp_word;
        int          exp_under;
        logic        exp_busy;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    i2s_seq_transmitter #(.DATA_W(DW), .SEQ_LEN(SL)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_lrc      (lrc),
        .i_load     (load),
        .i_seq_l    (seq_l),
        .i_seq_r    (seq_r),
        .o_dacdat   (dacdat),
        .o_ready    (ready),
        .o_busy     (busy),
        .o_underrun (underrun),
        .o_overflow (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (underrun) n_under++;
        if (overflow) n_over++;
    endtask

    task automatic set_data(input logic [15:0] lb, input logic [15:0] rb);
        for (int k = 0; k < SL; k++) begin
            seq_l[k] = lb + 16'(k);
            seq_r[k] = rb + 16'(k);
        end
    endtask

    task automatic do_load(input logic [15:0] lb, input logic [15:0] rb,
                           output logic rdy, output logic ovf);
        set_data(lb, rb);
        load = 1'b1;
        tick();
        load = 1'b0;
        rdy = ready;
        ovf = overflow;
    endtask

    task automatic run_slot(input logic l, input int len, input logic ld, output logic [15:0] w);
        lrc  = l;
        load = ld;
        w    = '0;
        for (int i = 0; i < len; i++) begin
            tick();
            if (i == 0) load = 1'b0;
            if (i < 16) w = {w[14:0], dacdat};
            else if (dacdat) tail_err++;
        end
    endtask

    initial begin
        logic [15:0] w;
        logic        rdy, ovf;
        int          u0;

        vecs[0] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 16'h6000, 16'h6000, 0, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 16'h0000, 16'h7000, 0, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 16'h0000, 16'h6001, 0, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 16'h0000, 16'h7001, 0, 1'b1, 1'b1};

        rst  = 1'b1;
        lrc  = 1'b0;
        load = 1'b0;
        set_data(16'h0, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst dacdat", dacdat, 0);
        check("rst ready", ready, 1);
        check("rst busy", busy, 0);
        check("rst underrun", underrun, 0);
        check("rst overflow", overflow, 0);
        rst = 1'b0;

        // idle with LR clock running, no data
        for (int s = 0; s < 5; s++) begin
            run_slot(s[0] ? 1'b0 : 1'b1, SLOT, 1'b0, w);
            check($sformatf("idle word %0d", s), w, 0);
        end
        check("idle ready", ready, 1);
        check("idle underrun count", n_under, 0);

        // block A loaded in a right slot; B loaded mid-stream; C overflows
        do_load(16'h1000, 16'h2000, rdy, ovf);
        check("A load ready", rdy, 0);
        check("A load ovf", ovf, 0);
        for (int k = 0; k < SL; k++) begin
            run_slot(1'b0, SLOT, 1'b0, w);
            check($sformatf("A L%0d", k), w, 32'h1000 + k);
            check($sformatf("A busy %0d", k), busy, 1);
            if (k == 0) check("A ready after swap", ready, 1);
            if (k == 5) begin
                do_load(16'h3000, 16'h4000, rdy, ovf);
                check("B load ready", rdy, 0);
                check("B load ovf", ovf, 0);
            end
            if (k == 10) begin
                do_load(16'h5000, 16'h5800, rdy, ovf);
                check("C load ovf", ovf, 1);
                check("C load ready", rdy, 0);
            end
            run_slot(1'b1, SLOT, 1'b0, w);
            check($sformatf("A R%0d", k), w, 32'h2000 + k);
        end
        check("A end ready", ready, 0);
        check("A end busy", busy, 1);
        for (int k = 0; k < SL; k++) begin
            run_slot(1'b0, SLOT, 1'b0, w);
            check($sformatf("B L%0d", k), w, 32'h3000 + k);
            check($sformatf("B busy %0d", k), busy, 1);
            if (k == 0) check("B ready after swap", ready, 1);
            run_slot(1'b1, SLOT, 1'b0, w);
            check($sformatf("B R%0d", k), w, 32'h4000 + k);
        end
        check("overflow pulses", n_over, 1);
        check("no underrun while streaming", n_under, 0);
        check("zero tail", tail_err, 0);

        // underrun frames, then bypass load coincident with a left edge
        foreach (vecs[i]) begin
            if (vecs[i].load) set_data(vecs[i].lbase, vecs[i].lbase + 16'h1000);
            u0 = n_under;
            run_slot(vecs[i].lrc, SLOT, vecs[i].load, w);
            check($sformatf("vec%0d word", i), w, vecs[i].exp_word);
            check($sformatf("vec%0d underrun", i), n_under - u0, vecs[i].exp_under);
            check($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
            check($sformatf("vec%0d ready", i), ready, vecs[i].exp_ready);
        end

        // reset mid-word in slot 7 of the bypassed block
        for (int k = 2; k < 7; k++) begin
            run_slot(1'b0, SLOT, 1'b0, w);
            check($sformatf("D L%0d", k), w, 32'h6000 + k);
            run_slot(1'b1, SLOT, 1'b0, w);
            check($sformatf("D R%0d", k), w, 32'h7000 + k);
        end
        lrc = 1'b0;
        tick();
        tick();
        check("slot7 bit14 before reset", dacdat, 1);
        rst = 1'b1;
        #1;
        check("mid-word rst dacdat", dacdat, 0);
        check("mid-word rst busy", busy, 0);
        check("mid-word rst ready", ready, 1);
        tick();
        tick();
        rst = 1'b0;
        u0 = n_under;
        do_load(16'h8000, 16'h9000, rdy, ovf);
        check("E load ready", rdy, 0);
        run_slot(1'b1, SLOT, 1'b0, w);
        check("E right start is zero", w, 0);
        check("E no start on right", busy, 0);
        // short left slot: right edge truncates the left word
        run_slot(1'b0, 10, 1'b0, w);
        check("E L0 truncated", w, 16'h0200);
        check("E busy", busy, 1);
        check("E ready", ready, 1);
        run_slot(1'b1, SLOT, 1'b0, w);
        check("E R0", w, 16'h9000);
        run_slot(1'b0, SLOT, 1'b0, w);
        check("E L1", w, 16'h8001);
        check("E no underrun after reset", n_under - u0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_seq_transmitter.md
Name: i2s_seq_transmitter

Overview:
- Output-side counterpart of the dynamic gate. It accepts one processed stereo block per load, with SEQ_LEN samples per channel.
- It serializes the block onto the codec DAC data line in I2S format, synchronized to the codec-driven DAC LR clock.
- It is double-buffered: a shadow bank accepts the next block while the active bank streams.
- It runs in the BCLK domain, between the gate and the codec pins.

Parameters:
- DATA_W, 16: bits per sample, sent MSB first.
- SEQ_LEN, 16: samples per channel per block.

Ports:
- i_clk  input  1  BCLK from the codec; all logic on posedge.
- i_rst  input  1  asynchronous, active-high reset.
- i_lrc  input  1  DACLRCK from the codec, synchronous to BCLK; low = left slot, high = right slot.
- i_load  input  1  one-cycle pulse; i_seq_l/i_seq_r are valid during this cycle.
- i_seq_l  input  DATA_W x SEQ_LEN  left-channel block.
- i_seq_r  input  DATA_W x SEQ_LEN  right-channel block.
- o_dacdat  output  1  serial DAC data, registered.
- o_ready  output  1  shadow bank empty; a load is accepted this cycle.
- o_busy  output  1  active bank streaming.
- o_underrun  output  1  one-cycle pulse: a left slot began with no data after streaming had started.
- o_overflow  output  1  one-cycle pulse: i_load arrived while o_ready=0.

Behaviour:

Reset:
- o_dacdat=0, o_ready=1, o_busy=0, o_underrun=0, o_overflow=0.
- Both banks invalid, sample index 0, shift count 0, lrc_q=0, started flag=0.
- Reset mid-stream aborts immediately; partial bits are never resumed.

Edge detection:
- lrc_q <= i_lrc every cycle.
- Falling edge (left start) = lrc_q=1 & i_lrc=0. Rising edge (right start) = lrc_q=0 & i_lrc=1.

Slot timing (I2S one-BCLK delay):
- At the posedge where an edge is detected, the selected word is loaded into the shifter and its bit DATA_W-1 is driven on o_dacdat at that same posedge.
- Bits DATA_W-2..0 follow on the next DATA_W-1 posedges.
- After the LSB, o_dacdat=0 until the next edge.
- If an edge arrives before all bits are sent, the new word reloads the shifter and the remaining old bits are dropped.

States:
- IDLE: o_busy=0.
  - At a falling edge with the shadow valid: move shadow to active, idx=0, send active_l[0], go to STREAM, set started.
  - At a falling edge with shadow empty and i_load=1 (and o_ready=1): bypass, i.e. load the inputs directly into active, send i_seq_l[0] the same cycle, go to STREAM.
  - At a falling edge with no data: send zero word; pulse o_underrun if started=1.
  - Rising edges in IDLE send zero word. Streaming never starts on a right slot.
- STREAM: o_busy=1.
  - Falling edge sends active_l[idx].
  - Rising edge sends active_r[idx], then idx++.
  - After idx SEQ_LEN-1 right is sent, the active bank is marked exhausted.
  - At the next falling edge: take the shadow if valid (stay in STREAM, idx=0, no gap); else apply the bypass/zero rules from IDLE and go to IDLE if no data.

Handshake:
- i_load with o_ready=1 captures both arrays into the shadow bank; o_ready=0 from the next cycle.
- On the bypass path, the load goes to the active bank instead and o_ready stays 1.
- o_ready returns to 1 the cycle after the shadow moves to active.
- i_load with o_ready=0 is ignored (shadow unchanged) and pulses o_overflow on the next cycle.

Data handling:
- Samples are transmitted verbatim; no sign handling or arithmetic.
- Index wrap is exact at SEQ_LEN; no sample is repeated or skipped across a block boundary.

Test Plan:
1. Reset release, i_lrc toggling every 32 BCLK, no load -> o_dacdat=0 throughout, o_underrun never pulses, o_ready=1.
2. Load L[k]=0x1000+k, R[k]=0x2000+k before a falling edge -> left slot k shows 0x1000+k MSB-first, with the MSB at the detected-edge posedge; right shows 0x2000+k; o_busy high for 16 LR frames.
3. Second load during streaming, third load before the swap -> second block follows with no zero gap, o_ready=0 until swap+1; third load produces o_overflow pulse and is dropped.
4. Block ends with no new data -> next left slot sends 0x0000, o_underrun pulses once per empty frame, o_busy=0.
5. i_load coincident with the falling edge while IDLE with shadow empty -> i_seq_l[0] MSB appears that same posedge (bypass), o_ready stays 1.
6. Assert i_rst mid-word in slot 7 -> o_dacdat=0 immediately; after release, a fresh load restarts at idx 0 on a falling edge only.
